// File: rtl/gpstb_snapshot_reader_if.sv
// Bus bundle for the snapshot reader: Wishbone pipelined read port toward the
// test-bench register bank plus the valid/ready record port toward the logger.
interface gpstb_snapshot_reader_if #(
  parameter int DW = 32
);
  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [2:0]      o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_stall;
  logic            i_wb_ack;
  logic            i_wb_err;
  logic [DW-1:0]   i_wb_data;
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_lcl;
  logic [31:0]     o_err_hi;
  logic [31:0]     o_err_lo;
  logic [63:0]     o_count;
  logic [63:0]     o_step;
  logic            o_busy;
  logic            o_fault;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
    output o_valid, o_lcl, o_err_hi, o_err_lo, o_count, o_step, o_busy, o_fault,
    input  i_ready
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
    input  o_valid, o_lcl, o_err_hi, o_err_lo, o_count, o_step, o_busy, o_fault,
    output i_ready
  );
endinterface

// File: rtl/gpstb_snapshot_reader.sv
// Wishbone pipelined master that reads registers 1..7 of the GPS-clock
// test-bench bank as one coherent snapshot and presents it as a single record.
module gpstb_snapshot_reader #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_trigger,
  gpstb_snapshot_reader_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  state_t        state_r;
  logic          cyc_r;
  logic          stb_r;
  logic          valid_r;
  logic          busy_r;
  logic          fault_r;
  logic [2:0]    addr_r;
  logic [2:0]    ack_cnt_r;
  logic [TW-1:0] tmo_r;
  logic [DW-1:0] slot_r [0:5];
  logic [31:0]   lcl_r;
  logic [31:0]   err_hi_r;
  logic [31:0]   err_lo_r;
  logic [63:0]   count_r;
  logic [63:0]   step_r;
  logic          abort_s;

  assign abort_s = bus.i_wb_err || (tmo_r == TMO_MAX);

  // Issue/collect FSM; the record registers only change when the 7th ack lands,
  // so an aborted or reset snapshot never leaks partial slots to the outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= ST_IDLE;
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      fault_r   <= 1'b0;
      addr_r    <= 3'd0;
      ack_cnt_r <= 3'd0;
      tmo_r     <= {TW{1'b0}};
      lcl_r     <= 32'd0;
      err_hi_r  <= 32'd0;
      err_lo_r  <= 32'd0;
      count_r   <= 64'd0;
      step_r    <= 64'd0;
      for (int i = 0; i < 6; i++) begin
        slot_r[i] <= {DW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_trigger) begin
            state_r   <= ST_REQ;
            cyc_r     <= 1'b1;
            stb_r     <= 1'b1;
            addr_r    <= 3'd1;
            busy_r    <= 1'b1;
            fault_r   <= 1'b0;
            ack_cnt_r <= 3'd0;
            tmo_r     <= {TW{1'b0}};
          end
        end
        ST_REQ, ST_WAIT: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            busy_r  <= 1'b0;
            fault_r <= 1'b1;
          end else begin
            // Abort fires at TMO_MAX, so this increment never passes it.
            tmo_r <= tmo_r + TW'(1);
            if (stb_r && !bus.i_wb_stall) begin
              if (addr_r == 3'd7) begin
                stb_r   <= 1'b0;
                state_r <= ST_WAIT;
              end else begin
                addr_r <= addr_r + 3'd1;
              end
            end
            if (bus.i_wb_ack) begin
              if (ack_cnt_r == 3'd6) begin
                lcl_r    <= slot_r[0];
                err_hi_r <= slot_r[1];
                err_lo_r <= slot_r[2];
                count_r  <= {slot_r[3], slot_r[4]};
                step_r   <= {slot_r[5], bus.i_wb_data};
                cyc_r    <= 1'b0;
                stb_r    <= 1'b0;
                valid_r  <= 1'b1;
                state_r  <= ST_OUT;
              end else begin
                slot_r[ack_cnt_r] <= bus.i_wb_data;
                ack_cnt_r         <= ack_cnt_r + 3'd1;
              end
            end
          end
        end
        ST_OUT: begin
          if (valid_r && bus.i_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_wb_cyc  = cyc_r;
  assign bus.o_wb_stb  = stb_r;
  assign bus.o_wb_we   = 1'b0;
  assign bus.o_wb_addr = addr_r;
  assign bus.o_wb_data = {DW{1'b0}};
  assign bus.o_wb_sel  = {(DW/8){1'b1}};
  assign bus.o_valid   = valid_r;
  assign bus.o_lcl     = lcl_r;
  assign bus.o_err_hi  = err_hi_r;
  assign bus.o_err_lo  = err_lo_r;
  assign bus.o_count   = count_r;
  assign bus.o_step    = step_r;
  assign bus.o_busy    = busy_r;
  assign bus.o_fault   = fault_r;

endmodule

// File: doc/gpstb_snapshot_reader.md
Name: gpstb_snapshot_reader

Overview:
- Wishbone pipelined bus master that reads one complete, coherent snapshot out of the GPS-clock test-bench register bank.
- On each trigger it issues seven single reads to addresses 1 through 7, in that order. The first read freezes the slave's snapshot and the last read releases it.
- Assembles the seven words into one record and presents it on a valid/ready output to the host-side logger.
- Sits between the PPS/trigger logic and the test-bench slave's configuration port.

Parameters:
- DW, 32, Wishbone data width; fixed at 32 because the record layout depends on it.
- TIMEOUT, 1023, maximum cycles between issuing the first strobe and receiving the seventh ack before the cycle is aborted.
- TW, 10, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_trigger  in  1  single-cycle request to start a snapshot read
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  always 0
- o_wb_addr  out  3  register address
- o_wb_data  out  DW  always 0
- o_wb_sel  out  DW/8  always all ones
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave ack
- i_wb_err  in  1  slave bus error
- i_wb_data  in  DW  read data
- o_valid  out  1  snapshot record valid
- i_ready  in  1  downstream accepts the record
- o_lcl  out  32  word from address 1 (local counter)
- o_err_hi  out  32  word from address 2
- o_err_lo  out  32  word from address 3
- o_count  out  64  {addr4, addr5}
- o_step  out  64  {addr6, addr7}
- o_busy  out  1  a read is in progress or a record is being held
- o_fault  out  1  sticky: the last attempt ended on bus error or timeout

Behaviour:
- Reset (asynchronous, active-low), required values:
  - o_wb_cyc=0, o_wb_stb=0, o_wb_addr=0.
  - o_valid=0, o_busy=0, o_fault=0, all data outputs 0.
  - State returns to IDLE.
  - Asserting reset mid-cycle drops o_wb_cyc immediately; no acks are counted after reset is released.
- State IDLE: when i_trigger=1, go to REQ on the next edge with o_wb_cyc=1, o_wb_stb=1, o_wb_addr=1. Clear o_fault, the ack counter and the timeout counter.
- State REQ (pipelined issue):
  - On each cycle where stb=1 and i_wb_stall=0, the address increments.
  - After address 7 is accepted, stb drops on the next edge and the state moves to WAIT.
  - Address is held stable while stalled.
  - Exactly 7 strobes are accepted per snapshot.
- Ack collection, in states REQ and WAIT:
  - Acks are counted 0..6. The data of ack k is stored into slot k+1, so acks map to addresses in issue order.
  - Slots 1..7 map to o_lcl, o_err_hi, o_err_lo, o_count[63:32], o_count[31:0], o_step[63:32], o_step[31:0].
  - An ack may arrive in the same cycle as a strobe is accepted.
  - When the 7th ack arrives: cyc drops on the next edge, o_valid is set, and the state moves to OUT.
- Abort:
  - Triggered by i_wb_err=1 in REQ or WAIT, or by the timeout counter reaching TIMEOUT.
  - Drops cyc and stb on the next edge, sets o_fault=1, returns to IDLE, and leaves o_valid=0.
  - Partially captured slots are not presented.
- State OUT:
  - Data outputs are stable while o_valid=1.
  - When i_valid... specifically, when o_valid && i_ready, o_valid clears on the next edge and the state returns to IDLE.
- i_trigger while the state is not IDLE is ignored; requests are not queued.
- o_busy = (state != IDLE).
- Acks seen while o_wb_cyc=0 are ignored.
- Timeout counter:
  - Counts every cycle in REQ and WAIT.
  - Saturates at TIMEOUT.
  - Does not wrap.
- Latency with no stalls and the slave acking one cycle after each strobe:
  - trigger at cycle 0, strobes at cycles 1..7, acks at cycles 2..8;
  - o_valid=1 at cycle 9.

Test Plan:
- Nominal: slave never stalls and acks one cycle after each strobe, returning 0x11,0x22,...,0x77. Pulse trigger at t0 -> addresses 1..7 on consecutive cycles; o_valid at t0+9; o_lcl=0x11, o_count=0x00000044_00000055, o_step=0x00000066_00000077.
- Stall: hold i_wb_stall=1 for 3 cycles while address 3 is on the bus -> addr stays at 3 for those cycles; 7 strobes total; record correct; o_valid at t0+12.
- Backpressure: hold i_ready=0 for 20 cycles, and pulse trigger at cycle 5 of that window -> outputs stable; no new cycle starts; the trigger is dropped; o_valid clears one cycle after i_ready=1.
- Bus error: assert i_wb_err on the 4th ack -> cyc=0 on the next edge; o_fault=1; o_valid never asserts. The next trigger clears o_fault and yields a full record.
- Timeout: set TIMEOUT=15 and let the slave stop acking after 2 acks -> cyc drops at cycle 16 after the first strobe; o_fault=1; state IDLE.
- Reset mid-operation: deassert i_reset_n during WAIT after 4 acks -> o_wb_cyc=0 in the same cycle; all outputs 0. After release, a trigger gives a correct fresh record that contains no stale slots.
